// File: rtl/bso_counter_if.sv
// Button-event and scoreboard-display bundle for the ball/strike/out engine.
// Signal names follow the display board's established pin names.
interface bso_counter_if;
   logic       iBALL;
   logic       iSTRIKE;
   logic       iFOUL;
   logic       iHIT;
   logic       iOUT;
   logic [1:0] oBALL;
   logic [1:0] oSTRIKE;
   logic [1:0] oOUT;
   logic [3:0] oINNING;
   logic       oTOP;
   logic       oWALK;
   logic       oSO;
   logic       oSIDE;
   logic       oEND;

   modport master (
      output iBALL, iSTRIKE, iFOUL, iHIT, iOUT,
      input  oBALL, oSTRIKE, oOUT, oINNING, oTOP, oWALK, oSO, oSIDE, oEND
   );

   modport slave (
      input  iBALL, iSTRIKE, iFOUL, iHIT, iOUT,
      output oBALL, oSTRIKE, oOUT, oINNING, oTOP, oWALK, oSO, oSIDE, oEND
   );
endinterface

// File: rtl/bso_counter.sv
// Ball/strike/out scoring engine: one prioritised event per cycle, registered
// count/inning outputs and one-cycle walk/strikeout/side-retired pulses.
module bso_counter #(
   parameter int unsigned MAX_INNING = 9
) (
   input  logic         iCLK,
   input  logic         iRST,
   bso_counter_if.slave bus
);
   localparam int unsigned CNT_W = 2;
   localparam int unsigned INN_W = 4;

   logic [CNT_W-1:0] ball_q, ball_d;
   logic [CNT_W-1:0] strike_q, strike_d;
   logic [CNT_W-1:0] out_q, out_d;
   logic [INN_W-1:0] inning_q, inning_d;
   logic             top_q, top_d;
   logic             walk_q, walk_d;
   logic             so_q, so_d;
   logic             side_q, side_d;
   logic             end_q, end_d;
   logic             adv_c;

   // Event decode in priority order OUT > HIT > STRIKE > FOUL > BALL, then out advance
   always_comb begin
      ball_d   = ball_q;
      strike_d = strike_q;
      out_d    = out_q;
      inning_d = inning_q;
      top_d    = top_q;
      walk_d   = 1'b0;
      so_d     = 1'b0;
      side_d   = 1'b0;
      end_d    = end_q;
      adv_c    = 1'b0;

      if (!end_q) begin
         if (bus.iOUT) begin
            ball_d   = '0;
            strike_d = '0;
            adv_c    = 1'b1;
         end else if (bus.iHIT) begin
            ball_d   = '0;
            strike_d = '0;
         end else if (bus.iSTRIKE) begin
            if (strike_q < CNT_W'(2)) begin
               strike_d = strike_q + CNT_W'(1);
            end else begin
               ball_d   = '0;
               strike_d = '0;
               so_d     = 1'b1;
               adv_c    = 1'b1;
            end
         end else if (bus.iFOUL) begin
            if (strike_q < CNT_W'(2)) begin
               strike_d = strike_q + CNT_W'(1);
            end
         end else if (bus.iBALL) begin
            if (ball_q < CNT_W'(3)) begin
               ball_d = ball_q + CNT_W'(1);
            end else begin
               ball_d   = '0;
               strike_d = '0;
               walk_d   = 1'b1;
            end
         end

         // Third out retires the side; bottom of the last inning ends the game
         if (adv_c) begin
            if (out_q < CNT_W'(2)) begin
               out_d = out_q + CNT_W'(1);
            end else begin
               out_d  = '0;
               side_d = 1'b1;
               if (top_q) begin
                  top_d = 1'b0;
               end else if (inning_q < INN_W'(MAX_INNING)) begin
                  top_d    = 1'b1;
                  inning_d = inning_q + INN_W'(1);
               end else begin
                  end_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         ball_q   <= '0;
         strike_q <= '0;
         out_q    <= '0;
         inning_q <= INN_W'(1);
         top_q    <= 1'b1;
         walk_q   <= 1'b0;
         so_q     <= 1'b0;
         side_q   <= 1'b0;
         end_q    <= 1'b0;
      end else begin
         ball_q   <= ball_d;
         strike_q <= strike_d;
         out_q    <= out_d;
         inning_q <= inning_d;
         top_q    <= top_d;
         walk_q   <= walk_d;
         so_q     <= so_d;
         side_q   <= side_d;
         end_q    <= end_d;
      end
   end

   assign bus.oBALL   = ball_q;
   assign bus.oSTRIKE = strike_q;
   assign bus.oOUT    = out_q;
   assign bus.oINNING = inning_q;
   assign bus.oTOP    = top_q;
   assign bus.oWALK   = walk_q;
   assign bus.oSO     = so_q;
   assign bus.oSIDE   = side_q;
   assign bus.oEND    = end_q;
endmodule

// File: tb/tb_bso_counter.sv
// Directed scoreboard bench for bso_counter built with MAX_INNING=2 so a whole
// game fits in a short run.
module tb_bso_counter;
   typedef struct packed {
      logic [1:0] ball;
      logic [1:0] strike;
      logic [1:0] outs;
      logic [3:0] inning;
      logic       top;
      logic       walk;
      logic       so;
      logic       side;
      logic       gend;
   } exp_t;

   // Event vector bit order: {out, hit, strike, foul, ball}
   localparam logic [4:0] EV_NONE = 5'b00000;
   localparam logic [4:0] EV_B    = 5'b00001;
   localparam logic [4:0] EV_F    = 5'b00010;
   localparam logic [4:0] EV_S    = 5'b00100;
   localparam logic [4:0] EV_H    = 5'b01000;
   localparam logic [4:0] EV_O    = 5'b10000;

   logic iCLK = 1'b0;
   logic iRST = 1'b1;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   bso_counter_if bus ();

   bso_counter #(.MAX_INNING(2)) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus.slave)
   );

   always #5 iCLK = ~iCLK;

   function automatic exp_t mk(input logic [1:0] b, input logic [1:0] s, input logic [1:0] o,
                               input logic [3:0] inn, input logic top, input logic walk,
                               input logic so, input logic side, input logic gend);
      exp_t e;
      e.ball = b; e.strike = s; e.outs = o; e.inning = inn; e.top = top;
      e.walk = walk; e.so = so; e.side = side; e.gend = gend;
      return e;
   endfunction

   // Drive one cycle of stimulus, queue its expected outcome, then check after the edge
   task automatic step(input logic [4:0] ev, input logic rst, input exp_t e, input string tag);
      exp_t exp_v;
      exp_t got;
      {bus.iOUT, bus.iHIT, bus.iSTRIKE, bus.iFOUL, bus.iBALL} = ev;
      iRST = rst;
      exp_q.push_back(e);
      @(posedge iCLK);
      #1;
      got = {bus.oBALL, bus.oSTRIKE, bus.oOUT, bus.oINNING, bus.oTOP,
             bus.oWALK, bus.oSO, bus.oSIDE, bus.oEND};
      exp_v = exp_q.pop_front();
      checks++;
      assert (got === exp_v) else begin
         errors++;
         $error("FAIL %s got b=%0d s=%0d o=%0d inn=%0d top=%0b w=%0b so=%0b side=%0b end=%0b exp b=%0d s=%0d o=%0d inn=%0d top=%0b w=%0b so=%0b side=%0b end=%0b",
                tag, got.ball, got.strike, got.outs, got.inning, got.top, got.walk, got.so,
                got.side, got.gend, exp_v.ball, exp_v.strike, exp_v.outs, exp_v.inning,
                exp_v.top, exp_v.walk, exp_v.so, exp_v.side, exp_v.gend);
      end
   endtask

   initial begin
      exp_t rv;
      rv = mk(2'd0, 2'd0, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      {bus.iOUT, bus.iHIT, bus.iSTRIKE, bus.iFOUL, bus.iBALL} = EV_NONE;
      #2;
      step(EV_NONE, 1'b1, rv, "reset");

      // Four balls: walk on the fourth
      step(EV_B, 1'b0, mk(2'd1, 2'd0, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "ball1");
      step(EV_B, 1'b0, mk(2'd2, 2'd0, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "ball2");
      step(EV_B, 1'b0, mk(2'd3, 2'd0, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "ball3");
      step(EV_B, 1'b0, mk(2'd0, 2'd0, 2'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "walk");
      step(EV_NONE, 1'b0, rv, "walk_clear");

      // Strikes, fouls at two strikes hold, third strike is an out
      step(EV_S, 1'b0, mk(2'd0, 2'd1, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "strike1");
      step(EV_S, 1'b0, mk(2'd0, 2'd2, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "strike2");
      step(EV_F, 1'b0, mk(2'd0, 2'd2, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "foul_a");
      step(EV_F, 1'b0, mk(2'd0, 2'd2, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "foul_b");
      step(EV_F, 1'b0, mk(2'd0, 2'd2, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "foul_c");
      step(EV_S, 1'b0, mk(2'd0, 2'd0, 2'd1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), "strikeout");
      step(EV_NONE, 1'b0, mk(2'd0, 2'd0, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "so_clear");

      // Priority: OUT beats STRIKE and BALL in one cycle
      step(EV_B, 1'b0, mk(2'd1, 2'd0, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "pri_b1");
      step(EV_B, 1'b0, mk(2'd2, 2'd0, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "pri_b2");
      step(EV_S, 1'b0, mk(2'd2, 2'd1, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "pri_s1");
      step(EV_O | EV_S | EV_B, 1'b0,
           mk(2'd0, 2'd0, 2'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "pri_out");
      // HIT beats FOUL and clears the count
      step(EV_B, 1'b0, mk(2'd1, 2'd0, 2'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "hit_pre");
      step(EV_H | EV_F, 1'b0, mk(2'd0, 2'd0, 2'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "hit");

      // Full game to MAX_INNING=2
      step(EV_NONE, 1'b1, rv, "reset2");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "t1_o1");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "t1_o2");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "t1_side");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "b1_o1");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "b1_o2");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), "b1_side");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "t2_o1");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "t2_o2");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "t2_side");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "b2_o1");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "b2_o2");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), "game_end");
      step(EV_B, 1'b0, mk(2'd0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "frozen_b");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "frozen_o");
      step(EV_NONE, 1'b1, rv, "reset_end");

      // Strikeout as third out raises oSO and oSIDE together
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "kso_o1");
      step(EV_O, 1'b0, mk(2'd0, 2'd0, 2'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "kso_o2");
      step(EV_S, 1'b0, mk(2'd0, 2'd1, 2'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "kso_s1");
      step(EV_S, 1'b0, mk(2'd0, 2'd2, 2'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "kso_s2");
      step(EV_S, 1'b0, mk(2'd0, 2'd0, 2'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "kso_side");

      // Reset wins over a simultaneous ball four
      step(EV_B, 1'b0, mk(2'd1, 2'd0, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rb_b1");
      step(EV_B, 1'b0, mk(2'd2, 2'd0, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rb_b2");
      step(EV_B, 1'b0, mk(2'd3, 2'd0, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rb_b3");
      step(EV_B, 1'b1, rv, "rst_vs_walk");

      // Reset the cycle after a walk pulse clears it
      step(EV_B, 1'b0, mk(2'd1, 2'd0, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "rp_b1");
      step(EV_B, 1'b0, mk(2'd2, 2'd0, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "rp_b2");
      step(EV_B, 1'b0, mk(2'd3, 2'd0, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "rp_b3");
      step(EV_B, 1'b0, mk(2'd0, 2'd0, 2'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "rp_walk");
      step(EV_NONE, 1'b1, rv, "rst_pulse");

      {bus.iOUT, bus.iHIT, bus.iSTRIKE, bus.iFOUL, bus.iBALL} = EV_NONE;
      iRST = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
